spu_issue_scoreboard: RTL
=========================

# spu_issue_scoreboard

Dual-issue hazard scoreboard for the SPU register fetch stage. It sits between the instruction buffer and the 128 x 128-bit register file. Each cycle it decides whether the even (slot 1) and odd (slot 2) instructions may read their operands and issue. A per-register latency countdown tracks results still in flight to the two write-back ports. Issue is strictly in order, and slot 2 never issues without slot 1.

## Interface
Parameters:
- NUM_REGS, 128, number of architectural registers
- ADDR_W, 7, register address width
- LAT_W, 3, width of latency field and per-register countdown; max latency 2^LAT_W-1

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- flush  in  1  branch/exception flush; clears scoreboard, blocks issue this cycle
- valid1, valid2  in  1  slot instruction present
- ra1, rb1, rc1, ra2, rb2, rc2  in  ADDR_W  source register addresses
- use_ra1, use_rb1, use_rc1, use_ra2, use_rb2, use_rc2  in  1  source actually read
- rt1, rt2  in  ADDR_W  destination register
- wr1, wr2  in  1  instruction writes rt
- lat1, lat2  in  LAT_W  result latency in cycles; 0 treated as 1
- issue1, issue2  out  1  combinational issue grants; operand reads valid this cycle
- stall  out  1  combinational; valid1 && !issue1
- busy_count  out  8  registered count of registers with nonzero countdown
- stall_count  out  32  registered, saturating count of cycles with stall=1

## Operation
- State: cnt[r], LAT_W bits, for each r in 0..NUM_REGS-1. Register r is ready iff cnt[r]==0.
- Slot 1 hazard, when valid1 is set:
  - any used source among ra1/rb1/rc1 not ready (RAW), or
  - wr1 && cnt[rt1]!=0 (WAW with in-flight result).
- issue1 = valid1 && !flush && !hazard1.
- Slot 2 hazard, when valid2 is set:
  - any hazard of the slot-1 kind evaluated on slot 2's own operands, or
  - wr1 and a used slot-2 source equals rt1 (intra-pair RAW), or
  - wr1 && wr2 && rt1==rt2 (intra-pair WAW).
- issue2 = valid2 && issue1 && !hazard2. Slot 2 is never granted alone. Re-presenting slot 2 as slot 1 is the upstream buffer's job.
- On issue of a slot with wr set, next cycle cnt[rt] = max(lat,1)-1.
- Every other register with cnt!=0 decrements by 1 each cycle.
- Load and decrement on the same register in the same cycle: the load wins.
- flush: next cycle every cnt = 0 and no load occurs. Results already in flight still write the register file; flush only drops tracking.
- busy_count: next-cycle population count of cnt!=0. Range 0..128.
- stall_count: increments when stall=1 and holds at 0xFFFFFFFF. Not cleared by flush.
- Reset values: all cnt=0, busy_count=0, stall_count=0. Hence issue1=valid1 and stall=0 after reset when flush=0. Reset asserted mid-operation clears everything immediately and asynchronously.

## Timing
- Grants are zero-latency: combinational from registered cnt and the current inputs.
- Slot issued in cycle T with latency L: a dependent source becomes ready and may issue in cycle T+L.
  - L=1 gives back-to-back issue at T+1.
  - L=6 puts the dependent at T+6.
- A destination written at T may be reused as a destination from cycle T+L.
- No handshake beyond valid/issue. Upstream holds slot inputs stable until granted.
- busy_count and stall_count lag events by exactly one cycle.

## Test plan
- Reset with valid1=1, ra1=5, use_ra1=1 -> issue1=1 in the first cycle after reset release; busy_count=0, stall_count=0.
- Slot 1 writes rt1=10 with lat1=6 at T; next instruction reads ra1=10 -> stall=1 for T+1..T+5, issue1=1 at T+6, stall_count=5.
- Pair with rt1=3, wr1=1 and slot 2 ra2=3 -> issue1=1, issue2=0. Pair with rt1=rt2=7 and both writing -> issue2=0. Independent pair with lat=2 -> both issue and busy_count=2 next cycle.
- Slot 1 stalled on r20 while slot 2 is independent -> issue1=0, issue2=0 (in-order).
- r9 busy with cnt=4; flush pulsed -> issue1=issue2=0 that cycle; next cycle cnt[9]=0, busy_count=0, and a reader of r9 issues.
- Assert reset asynchronously mid-stall with cnt[40]=3 -> all outputs return to reset values before the next edge. Separately, lat1=0 writing r2 at T -> reader of r2 issues at T+1.

Source files
------------

// File: rtl/spu_issue_scoreboard.sv
// rtl/spu_issue_scoreboard.sv - dual-issue register hazard scoreboard with per-register latency countdown
module spu_issue_scoreboard #(
  parameter int NUM_REGS = 128,
  parameter int ADDR_W   = 7,
  parameter int LAT_W    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              valid1,
  input  logic              valid2,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] rb1,
  input  logic [ADDR_W-1:0] rc1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [ADDR_W-1:0] rb2,
  input  logic [ADDR_W-1:0] rc2,
  input  logic              use_ra1,
  input  logic              use_rb1,
  input  logic              use_rc1,
  input  logic              use_ra2,
  input  logic              use_rb2,
  input  logic              use_rc2,
  input  logic [ADDR_W-1:0] rt1,
  input  logic [ADDR_W-1:0] rt2,
  input  logic              wr1,
  input  logic              wr2,
  input  logic [LAT_W-1:0]  lat1,
  input  logic [LAT_W-1:0]  lat2,
  output logic              issue1,
  output logic              issue2,
  output logic              stall,
  output logic [7:0]        busy_count,
  output logic [31:0]       stall_count
);

  logic [LAT_W-1:0]    cnt_q [NUM_REGS];
  logic [LAT_W-1:0]    cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic [7:0]          busy_count_q, busy_count_d;
  logic [31:0]         stall_count_q, stall_count_d;
  logic                hazard1, hazard2;
  logic [LAT_W-1:0]    load1, load2;

  // A register is busy while its result countdown is still running
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

  // Hazard detection and in-order grant; slot 2 also checks against slot 1's destination
  always_comb begin
    hazard1 = (use_ra1 && busy_vec[ra1]) || (use_rb1 && busy_vec[rb1]) ||
              (use_rc1 && busy_vec[rc1]) || (wr1 && busy_vec[rt1]);
    hazard2 = (use_ra2 && busy_vec[ra2]) || (use_rb2 && busy_vec[rb2]) ||
              (use_rc2 && busy_vec[rc2]) || (wr2 && busy_vec[rt2]) ||
              (wr1 && ((use_ra2 && (ra2 == rt1)) || (use_rb2 && (rb2 == rt1)) ||
                       (use_rc2 && (rc2 == rt1)))) ||
              (wr1 && wr2 && (rt1 == rt2));
    issue1  = valid1 && !flush && !hazard1;
    issue2  = valid2 && issue1 && !hazard2;
    stall   = valid1 && !issue1;
  end

  // Next countdown state: flush clears, a new issue loads (latency 0 behaves as 1), otherwise count down
  always_comb begin
    load1 = (lat1 == '0) ? '0 : lat1 - LAT_W'(1);
    load2 = (lat2 == '0) ? '0 : lat2 - LAT_W'(1);
    busy_count_d = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (flush) begin
        cnt_d[r] = '0;
      end else if (issue1 && wr1 && (rt1 == ADDR_W'(r))) begin
        cnt_d[r] = load1;
      end else if (issue2 && wr2 && (rt2 == ADDR_W'(r))) begin
        cnt_d[r] = load2;
      end else if (cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end else begin
        cnt_d[r] = cnt_q[r];
      end
      busy_count_d = busy_count_d + 8'(cnt_d[r] != '0);
    end
    stall_count_d = (stall && (stall_count_q != '1)) ? stall_count_q + 32'd1 : stall_count_q;
  end

  // State registers; reset clears tracking and statistics immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      busy_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      busy_count_q  <= busy_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign busy_count  = busy_count_q;
  assign stall_count = stall_count_q;

endmodule
